// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32I immediate decode with a 2-entry output FIFO.
//
// Each accepted instruction is classified by opcode into a format code and its
// immediate is built and sign-extended. The decoded entry {inst, pc, imm, fmt}
// is then written into a 2-deep in-order FIFO.
//
// Format codes: R=0, I=1, S=2, B=3, U=4, J=5, unknown opcode=7.
//
// Optional feature macro: IMM_ILLEGAL_DET_EN
//   Adds the out_illegal port. It flags unknown opcodes and SYSTEM encodings
//   with funct3 == 4, which is not a CSR variant.
//
// Ports:
//   clk         in   single clock, all state on rising edge
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   fetched instruction offered
//   in_ready    out  stage can accept (registered state only)
//   in_inst     in   raw RV32I instruction
//   in_pc       in   instruction PC
//   kill        in   synchronous flush; empties the FIFO and drops push/pop
//   out_valid   out  decoded entry available
//   out_ready   in   downstream accepts
//   out_inst    out  instruction of head entry (0 when empty)
//   out_pc      out  PC of head entry (0 when empty)
//   out_imm     out  sign-extended immediate of head entry (0 when empty)
//   out_fmt     out  format code of head entry (0 when empty)
//   out_illegal out  head is illegal (IMM_ILLEGAL_DET_EN only)
module imm_decode_stage #(
  parameter int INST_LEN = 32,
  parameter int REG_LEN  = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INST_LEN-1:0] in_inst,
  input  logic [ADDR_LEN-1:0] in_pc,
  input  logic                kill,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_LEN-1:0] out_inst,
  output logic [ADDR_LEN-1:0] out_pc,
  output logic [REG_LEN-1:0]  out_imm,
`ifdef IMM_ILLEGAL_DET_EN
  output logic                out_illegal,
`endif
  output logic [2:0]          out_fmt
);

  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
  localparam logic [2:0] FmtBad = 3'd7;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  // ---------------------------------------------------------------------------
  // Decode (combinational, ahead of the FIFO write)
  // ---------------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [31:0] w_ins;
  logic [31:0] w_imm32;
  logic [2:0]  w_fmt;

  assign w_ins    = 32'(in_inst);
  assign w_opcode = w_ins[6:0];

  always_comb begin
    w_fmt   = FmtBad;
    w_imm32 = 32'd0;
    case (w_opcode)
      OpLoad, OpImm, OpJalr, OpFence, OpSystem: begin
        w_fmt   = FmtI;
        w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
      end
      OpStore: begin
        w_fmt   = FmtS;
        w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      end
      OpBranch: begin
        w_fmt   = FmtB;
        w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        w_fmt   = FmtU;
        w_imm32 = {w_ins[31:12], 12'd0};
      end
      OpJal: begin
        w_fmt   = FmtJ;
        w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      end
      OpReg: begin
        w_fmt   = FmtR;
        w_imm32 = 32'd0;
      end
      default: begin
        w_fmt   = FmtBad;
        w_imm32 = 32'd0;
      end
    endcase
  end

`ifdef IMM_ILLEGAL_DET_EN
  logic w_illegal;
  // SYSTEM funct3 == 4 is the only non-ECALL/EBREAK, non-CSR encoding.
  assign w_illegal = (w_fmt == FmtBad) || ((w_opcode == OpSystem) && (w_ins[14:12] == 3'd4));
`endif

  // ---------------------------------------------------------------------------
  // 2-entry FIFO
  // ---------------------------------------------------------------------------
  logic [INST_LEN-1:0] r_inst [2];
  logic [ADDR_LEN-1:0] r_pc   [2];
  logic [REG_LEN-1:0]  r_imm  [2];
  logic [2:0]          r_fmt  [2];
`ifdef IMM_ILLEGAL_DET_EN
  logic                r_illegal [2];
`endif
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;
  // Held low through reset so in_ready rises only on the first edge after it.
  logic                r_alive;

  logic w_push;
  logic w_pop;
  logic w_nonempty;

  assign w_nonempty = (r_count != 2'd0);
  assign in_ready   = r_alive && (r_count != 2'd2);
  assign out_valid  = w_nonempty;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = w_nonempty && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_inst[i] <= '0;
        r_pc[i]   <= '0;
        r_imm[i]  <= '0;
        r_fmt[i]  <= '0;
`ifdef IMM_ILLEGAL_DET_EN
        r_illegal[i] <= 1'b0;
`endif
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_alive  <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (kill) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push) begin
          r_inst[r_wr_ptr] <= in_inst;
          r_pc[r_wr_ptr]   <= in_pc;
          r_imm[r_wr_ptr]  <= REG_LEN'(w_imm32);
          r_fmt[r_wr_ptr]  <= w_fmt;
`ifdef IMM_ILLEGAL_DET_EN
          r_illegal[r_wr_ptr] <= w_illegal;
`endif
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Outputs are forced to zero while empty so stale entries never leak.
  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    out_imm  = '0;
    out_fmt  = '0;
`ifdef IMM_ILLEGAL_DET_EN
    out_illegal = 1'b0;
`endif
    if (w_nonempty) begin
      out_inst = r_inst[r_rd_ptr];
      out_pc   = r_pc[r_rd_ptr];
      out_imm  = r_imm[r_rd_ptr];
      out_fmt  = r_fmt[r_rd_ptr];
`ifdef IMM_ILLEGAL_DET_EN
      out_illegal = r_illegal[r_rd_ptr];
`endif
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
`ifdef IMM_ILLEGAL_DET_EN
  logic        out_illegal;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_decode_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_imm   (out_imm),
`ifdef IMM_ILLEGAL_DET_EN
    .out_illegal (out_illegal),
`endif
    .out_fmt   (out_fmt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic k);
    @(negedge clk);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    kill      = k;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    kill      = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_imm",   out_imm,        32'd0);
    check("rst_out_fmt",   32'(out_fmt),   32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready_before_edge", 32'(in_ready), 32'd0);
    step();
    check("post_rst_in_ready_after_edge", 32'(in_ready), 32'd1);

    // I-type, latency 1
    drive(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    step();
    check("i_valid", 32'(out_valid), 32'd1);
    check("i_fmt",   32'(out_fmt),   32'd1);
    check("i_imm",   out_imm,        32'hFFFFFFFF);
    check("i_inst",  out_inst,       32'hFFF00093);
    check("i_pc",    out_pc,         32'h100);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("i_drained_valid", 32'(out_valid), 32'd0);
    check("i_drained_imm",   out_imm,        32'd0);

    // S then B with downstream stalled: fill to 2
    drive(1'b1, 32'h00112623, 32'h104, 1'b0, 1'b0);
    step();
    check("s_in_ready_one", 32'(in_ready), 32'd1);
    drive(1'b1, 32'hFE000EE3, 32'h108, 1'b0, 1'b0);
    step();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("s_imm",         out_imm,       32'h0000000C);
    check("s_fmt",         32'(out_fmt),  32'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check("s_hold_imm", out_imm, 32'h0000000C);
    check("s_hold_pc",  out_pc,  32'h104);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("b_imm",      out_imm,        32'hFFFFFFFC);
    check("b_fmt",      32'(out_fmt),   32'd3);
    check("b_pc",       out_pc,         32'h108);
    check("b_in_ready", 32'(in_ready),  32'd1);
    step();
    check("sb_drained", 32'(out_valid), 32'd0);

    // U then J back-to-back, push+pop at count 1
    drive(1'b1, 32'h12345037, 32'h200, 1'b1, 1'b0);
    step();
    check("u_imm", out_imm,      32'h12345000);
    check("u_fmt", 32'(out_fmt), 32'd4);
    drive(1'b1, 32'h0080006F, 32'h204, 1'b1, 1'b0);
    step();
    check("j_imm",      out_imm,        32'h00000008);
    check("j_fmt",      32'(out_fmt),   32'd5);
    check("j_valid",    32'(out_valid), 32'd1);
    check("j_in_ready", 32'(in_ready),  32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("uj_drained", 32'(out_valid), 32'd0);

    // R-type and SYSTEM encodings
    drive(1'b1, 32'h002081B3, 32'h300, 1'b1, 1'b0);
    step();
    check("r_fmt", 32'(out_fmt), 32'd0);
    check("r_imm", out_imm,      32'd0);
    drive(1'b1, 32'h30001073, 32'h304, 1'b1, 1'b0);
    step();
    check("csr_fmt", 32'(out_fmt), 32'd1);
    check("csr_imm", out_imm,      32'h00000300);
`ifdef IMM_ILLEGAL_DET_EN
    check("csr_illegal", 32'(out_illegal), 32'd0);
`endif
    drive(1'b1, 32'h00004073, 32'h308, 1'b1, 1'b0);
    step();
    check("sys4_fmt", 32'(out_fmt), 32'd1);
`ifdef IMM_ILLEGAL_DET_EN
    check("sys4_illegal", 32'(out_illegal), 32'd1);
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("sys_drained", 32'(out_valid), 32'd0);

    // Kill at count 2 with a push offered
    drive(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
    step();
    check("kill_pre_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h00300093, 32'h408, 1'b1, 1'b1);
    step();
    check("kill_valid",    32'(out_valid), 32'd0);
    check("kill_in_ready", 32'(in_ready),  32'd1);
    check("kill_inst",     out_inst,       32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    check("kill_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-cycle with an entry held
    drive(1'b1, 32'h00500093, 32'h500, 1'b0, 1'b0);
    step();
    check("pre_arst_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid",    32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready),  32'd0);
    check("arst_imm",      out_imm,        32'd0);
    check("arst_inst",     out_inst,       32'd0);
    check("arst_pc",       out_pc,         32'd0);
`ifdef IMM_ILLEGAL_DET_EN
    check("arst_illegal",  32'(out_illegal), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rearm_in_ready", 32'(in_ready), 32'd1);

    // Unknown opcode
    drive(1'b1, 32'h0000007F, 32'h600, 1'b0, 1'b0);
    step();
    check("bad_fmt",   32'(out_fmt),   32'd7);
    check("bad_imm",   out_imm,        32'd0);
    check("bad_valid", 32'(out_valid), 32'd1);
`ifdef IMM_ILLEGAL_DET_EN
    check("bad_illegal", 32'(out_illegal), 32'd1);
`endif
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL use the following compile-time widths from param.v:
- INST_LEN, 32, instruction width.
- REG_LEN, 32, immediate/data width.
- ADDR_LEN, 32, PC width.

REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetched instruction offered.
- in_ready  out  1  stage can accept.
- in_inst  in  INST_LEN  raw RV32I instruction.
- in_pc  in  ADDR_LEN  instruction PC.
- kill  in  1  synchronous flush (branch mispredict).
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts.
- out_inst  out  INST_LEN  instruction of head entry.
- out_pc  out  ADDR_LEN  PC of head entry.
- out_imm  out  REG_LEN  selected, sign-extended immediate.
- out_fmt  out  3  format code.
- out_illegal  out  1  illegal opcode; present only with IMM_ILLEGAL_DET_EN.

Function
REQ-003 SHALL classify inst[6:0] into out_fmt as follows:
- I=1: 0000011, 0010011, 1100111, 0001111, 1110011.
- S=2: 0100011.
- B=3: 1100011.
- U=4: 0110111, 0010111.
- J=5: 1101111.
- R=0: 0110011.
- Any other opcode: 7.

REQ-004 SHALL compute immediates per RV32I before registering:
- I = sign-extended inst[31:20].
- S = sign-extended {inst[31:25], inst[11:7]}.
- B = sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- U = {inst[31:12], 12'b0}.
- J = sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- R and code 7: 0.

REQ-005 SHALL store decoded entries {inst, pc, imm, fmt} in a 2-entry in-order FIFO; a transfer occurs on valid&&ready at a clock edge.
REQ-006 SHALL have latency 1: an entry accepted at edge N is visible on out_* with out_valid=1 after edge N when the FIFO was empty.
REQ-007 SHALL drive in_ready = (count != 2) from registered state only; no combinational path from out_ready to in_ready.
REQ-008 SHALL drive out_valid = (count != 0); out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 SHALL handle simultaneous push and pop at count=1 by keeping count=1 and presenting the new entry after the edge.
REQ-010 SHALL handle simultaneous push and pop at count=0 as a push only (out_valid is low, so no pop occurs).
REQ-011 SHALL wrap read and write pointers modulo 2; count SHALL never exceed 2 or go below 0.
REQ-012 SHALL give kill priority: on kill=1 at an edge, count becomes 0, and push and pop in that cycle are discarded.
REQ-013 SHALL hold out_inst, out_pc, out_imm and out_fmt at 0 whenever count=0.

Reset
REQ-014 SHALL, on reset_n=0 and independent of clk, clear count and both pointers, and set out_valid=0, in_ready=0, and out_inst/out_pc/out_imm/out_fmt/out_illegal=0.
REQ-015 SHALL raise in_ready on the first rising edge after reset_n deasserts; entries in flight during reset are lost.

Configuration
REQ-016 SHALL, with IMM_ILLEGAL_DET_EN defined:
- provide out_illegal = (head fmt == 7) && out_valid;
- also flag SYSTEM opcodes whose funct3 != 0 and which are not CSR variants (funct3 = 4 is illegal).
REQ-017 SHALL, with IMM_ILLEGAL_DET_EN undefined:
- omit the out_illegal port;
- report fmt 7 without an extra flag;
- match the enabled build in all other behaviour.

Verification
REQ-018 Push 0xFFF00093 into empty stage, out_ready=1 -> one edge later out_valid=1, out_fmt=1, out_imm=0xFFFFFFFF.
REQ-019 Push 0x00112623, then 0xFE000EE3, with out_ready=0 -> in_ready drops to 0 after the second push; head holds imm=0x0000000C, fmt=2. Raising out_ready then yields imm=0xFFFFFFFC, fmt=3.
REQ-020 Push 0x12345037 and 0x0080006F back-to-back with out_ready=1 -> outputs (0x12345000, fmt 4) then (0x00000008, fmt 5), with no bubble and count never reaching 2.
REQ-021 With count=2, assert kill together with in_valid=1 -> count=0 and out_valid=0 after the edge; the offered instruction is dropped.
REQ-022 Drive reset_n low mid-transfer between clock edges -> outputs are zero immediately; with IMM_ILLEGAL_DET_EN defined, push 0x0000007F -> out_fmt=7, out_illegal=1.
